hex_scan_ctrl: RTL and testbench
================================

Name: hex_scan_ctrl

Overview:
Time-multiplexing controller that shares one combinational hex-to-7-segment decoder across NUM_DIGITS common-anode digits. It holds a multi-digit value and scans the digits in turn, one per slot. For each slot it drives the shared decoder's 4-bit input, registers the returned segment pattern, and pulses that digit's active-low anode. It sits between the value producer, which uses a valid/ready load handshake, and the display pins.

Parameters:
NUM_DIGITS, 4, number of digits scanned (≥2)
REFRESH_DIV, 1000, cycles a digit's anode is on per slot (≥1)
BLANK_CYCLES, 2, anti-ghosting cycles with all anodes off before each digit (≥1)
LZ_SUPPRESS, 1, 1 = blank leading zero digits (digit 0 is never blanked)

Ports:
clk  in  1  system clock
rst_n  in  1  reset, synchronous, active-low
enable  in  1  scan enable; low = display dark
load_valid  in  1  producer offers load_value
load_ready  out  1  controller can accept a value
load_value  in  4*NUM_DIGITS  nibble i = digit i; digit 0 = least significant
hex_digit  out  4  registered nibble driven into the shared decoder
segments_in  in  7  decoder output, combinational from hex_digit, active-low
seg_out  out  7  registered segment pins, active-low
an_n  out  NUM_DIGITS  anode enables, active-low, at most one low at a time

Behaviour:
- Reset (rst_n low at posedge): an_n = all 1, seg_out = 7'h7F, hex_digit = 0, load_ready = 1, active = 0, shadow empty, idx = 0, state = BLANK, counter = 0.
- States: OFF, BLANK, SHOW.
- BLANK: an_n = all 1; hex_digit = active nibble[idx]; lasts BLANK_CYCLES cycles, then go to SHOW.
- SHOW: lasts REFRESH_DIV cycles. an_n[idx] = 0 unless the digit is suppressed. At the end of SHOW, idx advances and wraps from NUM_DIGITS-1 to 0, then go to BLANK.
- Per-digit period = BLANK_CYCLES + REFRESH_DIV cycles. Frame = NUM_DIGITS × period.
- seg_out <= segments_in every cycle while in BLANK or SHOW. Because BLANK_CYCLES ≥ 1, seg_out is valid when the anode turns on.
- Suppressed digit (LZ_SUPPRESS = 1, idx > 0, and all nibbles at positions ≥ idx are 0): an_n stays all 1 and seg_out = 7'h7F for that whole slot. Slot timing is unchanged.
- Load handshake:
  - Transfer occurs when load_valid && load_ready at a posedge.
  - load_ready = !pending.
  - An accepted value goes to the shadow register and sets pending.
  - Frame boundary = the cycle on which idx wraps to 0. On that cycle, shadow → active, pending clears, and load_ready returns to 1 on the next cycle. The display never tears mid-frame.
  - If a load is accepted on the frame-boundary cycle itself, the incoming value goes directly to active and pending stays clear.
- enable low: the next cycle is OFF, with an_n = all 1 and seg_out = 7'h7F. Loads are still accepted. While in OFF, any pending value transfers to active immediately.
- enable rising: restart at idx = 0 in BLANK with counter = 0.
- Reset mid-operation discards pending/shadow and the current slot.

Decomposition:
- Package hex_display_pkg:
  - state enum {OFF, BLANK, SHOW}
  - SEG_BLANK = 7'h7F
  - NIBBLE_W = 4
  - function lz_mask(value) returning the per-digit suppress vector.
- One natural sub-module: hex_scan_timer. It is the slot counter that generates the blank_done / show_done strobes and the idx wrap (frame_end) strobe.
- The decoder is not instantiated inside this block; it connects externally via hex_digit / segments_in.

Test Plan (bench instantiates the existing decoder; NUM_DIGITS=4, REFRESH_DIV=4, BLANK_CYCLES=2, period = 6 cycles, frame = 24 cycles):
1. Basic scan: reset, enable = 1, load 16'h12A0 at frame start → each digit's anode is low for exactly 4 cycles after 2 dark cycles, in this order:
   - an_n = 1110, seg_out = 7'h40
   - an_n = 1101, seg_out = 7'h08
   - an_n = 1011, seg_out = 7'h24
   - an_n = 0111, seg_out = 7'h79
2. Shadow / no tearing: load 16'h0003 while idx = 2 → load_ready = 0 on the next cycle; a second load_valid is not accepted; digits 2-3 still show the old value; the new value appears from idx = 0 of the next frame; load_ready = 1 on the cycle after the wrap.
3. Leading-zero suppression:
   - Load 16'h0005 → an_n stays 1111 during the slots for digits 1-3; digit 0 shows 7'h12.
   - Load 16'h0000 → digit 0 shows 7'h40.
   - Load 16'h0100 → digit 1 shows 7'h40 with its anode on; digit 3 is suppressed.
4. Simultaneous load at frame boundary: load_valid on the wrap cycle → the new value becomes active immediately; load_ready stays 1; no extra frame of delay.
5. Enable toggle: drop enable mid-SHOW of digit 2 → the next cycle has an_n = 1111, seg_out = 7'h7F; raise enable → 2 BLANK cycles, then an_n = 1110.
6. Reset mid-operation: rst_n low for one cycle during digit 1 SHOW with a pending shadow → every output is at its reset value after that edge; the pending value is lost; the display shows 0 on digit 0 only.

Source files
------------

// File: rtl/hex_display_pkg.sv
// Shared types, constants and helpers for the multiplexed hex display controller.
package hex_display_pkg;

    // Scan controller states
    typedef enum logic [1:0] {
        OFF   = 2'd0,
        BLANK = 2'd1,
        SHOW  = 2'd2
    } state_e;

    localparam logic [6:0] SEG_BLANK  = 7'h7F;
    localparam int         NIBBLE_W   = 4;
    // Upper bound on digits the suppress helper handles; NUM_DIGITS must not exceed it
    localparam int         MAX_DIGITS = 16;
    localparam int         MAX_IDX_W  = 4;
    localparam int         LZ_W       = NIBBLE_W * MAX_DIGITS;

    // Bit i set when digit i is a leading zero: every nibble at or above i is zero.
    // Digit 0 is never flagged so a zero value still shows a single "0".
    function automatic logic [MAX_DIGITS-1:0] lz_mask(input logic [LZ_W-1:0] value);
        logic [MAX_DIGITS-1:0] mask;
        logic                  upper_zero;
        mask       = '0;
        upper_zero = 1'b1;
        for (int i = MAX_DIGITS - 1; i >= 0; i--) begin
            upper_zero = upper_zero && (value[i*NIBBLE_W +: NIBBLE_W] == '0);
            mask[i]    = upper_zero && (i != 0);
        end
        return mask;
    endfunction

endpackage

// File: rtl/hex_scan_timer.sv
// Slot timer: counts BLANK and SHOW durations, steps the digit index and
// flags the frame wrap. Any cycle spent in OFF rearms it at digit 0, count 0.
module hex_scan_timer
    import hex_display_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 1000,
    parameter int BLANK_CYCLES = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  state_e                        state,
    output logic                          blank_done,
    output logic                          show_done,
    output logic                          frame_end,
    output logic [$clog2(NUM_DIGITS)-1:0] idx_next
);

    localparam int IDX_W   = $clog2(NUM_DIGITS);
    localparam int CNT_MAX = (BLANK_CYCLES > REFRESH_DIV) ? BLANK_CYCLES : REFRESH_DIV;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             last_idx;

    // Strobes for the current cycle and next counter / index values
    always_comb begin
        blank_done = (state == BLANK) && (cnt_q == CNT_W'(BLANK_CYCLES - 1));
        show_done  = (state == SHOW)  && (cnt_q == CNT_W'(REFRESH_DIV - 1));
        last_idx   = (idx_q == IDX_W'(NUM_DIGITS - 1));
        frame_end  = show_done && last_idx;
        cnt_d      = cnt_q + 1'b1;
        idx_d      = idx_q;
        if (state == OFF) begin
            cnt_d = '0;
            idx_d = '0;
        end else if (blank_done) begin
            cnt_d = '0;
        end else if (show_done) begin
            cnt_d = '0;
            idx_d = last_idx ? '0 : idx_q + 1'b1;
        end
        idx_next = idx_d;
    end

    // Counter and index registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
            idx_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            idx_q <= idx_d;
        end
    end

endmodule

// File: rtl/hex_scan_ctrl.sv
// Time-multiplexed hex display controller. Drives one shared external
// hex-to-7-segment decoder, registers its output and strobes one active-low
// anode per slot, with dark BLANK cycles between digits to stop ghosting.
// New values are double-buffered and only take effect at a frame wrap.
module hex_scan_ctrl
    import hex_display_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 1000,
    parameter int BLANK_CYCLES = 2,
    parameter int LZ_SUPPRESS  = 1
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           enable,
    input  logic                           load_valid,
    output logic                           load_ready,
    input  logic [NIBBLE_W*NUM_DIGITS-1:0] load_value,
    output logic [NIBBLE_W-1:0]            hex_digit,
    input  logic [6:0]                     segments_in,
    output logic [6:0]                     seg_out,
    output logic [NUM_DIGITS-1:0]          an_n
);

    localparam int IDX_W = $clog2(NUM_DIGITS);
    localparam int VAL_W = NIBBLE_W * NUM_DIGITS;

    state_e                  state_q, state_d;
    logic [VAL_W-1:0]        active_q, active_d;
    logic [VAL_W-1:0]        shadow_q, shadow_d;
    logic                    pending_q, pending_d;
    logic [NIBBLE_W-1:0]     hex_digit_q, hex_digit_d;
    logic [6:0]              seg_out_q, seg_out_d;
    logic [NUM_DIGITS-1:0]   an_n_q, an_n_d;

    logic                    blank_done, show_done, frame_end;
    logic [IDX_W-1:0]        idx_next;
    logic                    accept, xfer, supp_next;
    logic [MAX_DIGITS-1:0]   lz_full;

    hex_scan_timer #(
        .NUM_DIGITS  (NUM_DIGITS),
        .REFRESH_DIV (REFRESH_DIV),
        .BLANK_CYCLES(BLANK_CYCLES)
    ) u_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .state     (state_q),
        .blank_done(blank_done),
        .show_done (show_done),
        .frame_end (frame_end),
        .idx_next  (idx_next)
    );

    // Next-state logic: enable low forces OFF; OFF always restarts in BLANK
    always_comb begin
        state_d = state_q;
        if (!enable) begin
            state_d = OFF;
        end else begin
            case (state_q)
                OFF:     state_d = BLANK;
                BLANK:   if (blank_done) state_d = SHOW;
                SHOW:    if (show_done)  state_d = BLANK;
                default: state_d = BLANK;
            endcase
        end
    end

    // Load handshake and shadow/active double buffer; a load landing on a
    // transfer cycle bypasses the shadow so it costs no extra frame
    always_comb begin
        accept    = load_valid && !pending_q;
        xfer      = frame_end || (state_q == OFF);
        active_d  = active_q;
        shadow_d  = shadow_q;
        pending_d = pending_q;
        if (xfer) begin
            if (accept) begin
                active_d = load_value;
            end else if (pending_q) begin
                active_d = shadow_q;
            end
            pending_d = 1'b0;
        end else if (accept) begin
            shadow_d  = load_value;
            pending_d = 1'b1;
        end
    end

    // Output registers are loaded from next-cycle state/index/value so they
    // line up with the slot they belong to
    always_comb begin
        hex_digit_d = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx_next == IDX_W'(i)) begin
                hex_digit_d = active_d[i*NIBBLE_W +: NIBBLE_W];
            end
        end
        lz_full   = lz_mask(LZ_W'(active_d));
        supp_next = (LZ_SUPPRESS != 0) && lz_full[MAX_IDX_W'(idx_next)];

        if (state_d == SHOW && !supp_next) begin
            an_n_d = ~(NUM_DIGITS'(1) << idx_next);
        end else begin
            an_n_d = '1;
        end

        if (state_d == OFF || supp_next || state_q == OFF) begin
            seg_out_d = SEG_BLANK;
        end else begin
            seg_out_d = segments_in;
        end
    end

    // State, buffers and pin registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= BLANK;
            active_q    <= '0;
            shadow_q    <= '0;
            pending_q   <= 1'b0;
            hex_digit_q <= '0;
            seg_out_q   <= SEG_BLANK;
            an_n_q      <= '1;
        end else begin
            state_q     <= state_d;
            active_q    <= active_d;
            shadow_q    <= shadow_d;
            pending_q   <= pending_d;
            hex_digit_q <= hex_digit_d;
            seg_out_q   <= seg_out_d;
            an_n_q      <= an_n_d;
        end
    end

    assign load_ready = !pending_q;
    assign hex_digit  = hex_digit_q;
    assign seg_out    = seg_out_q;
    assign an_n       = an_n_q;

endmodule

// File: tb/tb_hex_scan_ctrl.sv
// Bench for hex_scan_ctrl: 4 digits, 2 blank + 4 show cycles per slot
// (6-cycle slot, 24-cycle frame), with a behavioural stand-in for the decoder.
module tb_hex_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic        load_valid;
    logic        load_ready;
    logic [15:0] load_value;
    logic [3:0]  hex_digit;
    logic [6:0]  segments_in;
    logic [6:0]  seg_out;
    logic [3:0]  an_n;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [15:0]     value;
        logic [3:0][3:0] an_exp;
        logic [3:0][6:0] seg_exp;
    } vec_t;

    vec_t vecs [5];

    hex_scan_ctrl #(
        .NUM_DIGITS  (4),
        .REFRESH_DIV (4),
        .BLANK_CYCLES(2),
        .LZ_SUPPRESS (1)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_value (load_value),
        .hex_digit  (hex_digit),
        .segments_in(segments_in),
        .seg_out    (seg_out),
        .an_n       (an_n)
    );

    always #5 clk = ~clk;

    // Active-low gfedcba hex decoder
    function automatic logic [6:0] hex7(input logic [3:0] h);
        case (h)
            4'h0: return 7'h40; 4'h1: return 7'h79; 4'h2: return 7'h24; 4'h3: return 7'h30;
            4'h4: return 7'h19; 4'h5: return 7'h12; 4'h6: return 7'h02; 4'h7: return 7'h78;
            4'h8: return 7'h00; 4'h9: return 7'h10; 4'hA: return 7'h08; 4'hB: return 7'h03;
            4'hC: return 7'h46; 4'hD: return 7'h21; 4'hE: return 7'h06; default: return 7'h0E;
        endcase
    endfunction

    always_comb segments_in = hex7(hex_digit);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic advance(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    // Load through the OFF state so the value is active at once, then restart;
    // returns at the first BLANK cycle of a frame (t = 0)
    task automatic load_off(input logic [15:0] v);
        enable = 1'b0;
        tick();
        load_valid = 1'b1;
        load_value = v;
        tick();
        load_valid = 1'b0;
        enable     = 1'b1;
        tick();
    endtask

    task automatic check_pins(input string tag, input logic [3:0] an_e, input logic [6:0] seg_e);
        check({tag, " an_n"}, 32'(an_n), 32'(an_e));
        check({tag, " seg_out"}, 32'(seg_out), 32'(seg_e));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, required $finish");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{value: 16'h12A0, an_exp: {4'h7, 4'hB, 4'hD, 4'hE}, seg_exp: {7'h79, 7'h24, 7'h08, 7'h40}};
        vecs[1] = '{value: 16'h0005, an_exp: {4'hF, 4'hF, 4'hF, 4'hE}, seg_exp: {7'h7F, 7'h7F, 7'h7F, 7'h12}};
        vecs[2] = '{value: 16'h0000, an_exp: {4'hF, 4'hF, 4'hF, 4'hE}, seg_exp: {7'h7F, 7'h7F, 7'h7F, 7'h40}};
        vecs[3] = '{value: 16'h0100, an_exp: {4'hF, 4'hB, 4'hD, 4'hE}, seg_exp: {7'h7F, 7'h79, 7'h40, 7'h40}};
        vecs[4] = '{value: 16'h3F0E, an_exp: {4'h7, 4'hB, 4'hD, 4'hE}, seg_exp: {7'h30, 7'h0E, 7'h40, 7'h06}};

        rst_n      = 1'b0;
        enable     = 1'b0;
        load_valid = 1'b0;
        load_value = '0;
        advance(2);
        check_pins("reset", 4'hF, 7'h7F);
        check("reset hex_digit", 32'(hex_digit), 32'h0);
        check("reset load_ready", 32'(load_ready), 32'h1);
        rst_n = 1'b1;

        // Table-driven full-frame scans, including leading-zero suppression
        for (int v = 0; v < 5; v++) begin
            load_off(vecs[v].value);
            for (int d = 0; d < 4; d++) begin
                for (int b = 0; b < 2; b++) begin
                    check($sformatf("v%0d d%0d blank%0d an_n", v, d, b), 32'(an_n), 32'hF);
                    if (b == 1)
                        check($sformatf("v%0d d%0d blank seg_out", v, d), 32'(seg_out), 32'(vecs[v].seg_exp[d]));
                    tick();
                end
                for (int s = 0; s < 4; s++) begin
                    check_pins($sformatf("v%0d d%0d show%0d", v, d, s), vecs[v].an_exp[d], vecs[v].seg_exp[d]);
                    check($sformatf("v%0d d%0d show%0d hex_digit", v, d, s),
                          32'(hex_digit), 32'(vecs[v].value[d*4 +: 4]));
                    tick();
                end
            end
        end

        // Shadow load mid-frame: no tearing, second offer refused
        load_off(16'h12A0);
        advance(13);
        load_valid = 1'b1;
        load_value = 16'h0003;
        tick();                                    // t=14, accepted into shadow
        load_value = 16'h0777;
        check("shadow load_ready low", 32'(load_ready), 32'h0);
        check_pins("shadow d2 old", 4'hB, 7'h24);
        tick();                                    // t=15, must not be taken
        load_valid = 1'b0;
        advance(5);                                // t=20
        check_pins("shadow d3 old", 4'h7, 7'h79);
        advance(3);                                // t=23, wrap cycle
        check("shadow pending at wrap", 32'(load_ready), 32'h0);
        tick();                                    // t=0 of next frame
        check("shadow ready after wrap", 32'(load_ready), 32'h1);
        advance(2);
        check_pins("shadow new d0", 4'hE, 7'h30);
        advance(6);
        check_pins("shadow new d1 suppressed", 4'hF, 7'h7F);

        // Load accepted on the wrap cycle goes straight to active
        load_off(16'h12A0);
        advance(23);
        check("wrap load_ready before", 32'(load_ready), 32'h1);
        load_valid = 1'b1;
        load_value = 16'h4321;
        tick();
        load_valid = 1'b0;
        check("wrap load_ready after", 32'(load_ready), 32'h1);
        advance(2);
        check_pins("wrap new d0", 4'hE, 7'h79);
        advance(6);
        check_pins("wrap new d1", 4'hD, 7'h24);

        // Enable dropped mid-SHOW of digit 2, then restarted
        advance(6);
        check_pins("en d2 show", 4'hB, 7'h30);
        enable = 1'b0;
        tick();
        check_pins("en off", 4'hF, 7'h7F);
        enable = 1'b1;
        tick();
        check("en restart blank1 an_n", 32'(an_n), 32'hF);
        tick();
        check("en restart blank2 an_n", 32'(an_n), 32'hF);
        tick();
        check_pins("en restart d0", 4'hE, 7'h79);

        // Reset during digit 1 SHOW with a value pending in the shadow
        advance(6);
        check_pins("rst d1 show", 4'hD, 7'h24);
        load_valid = 1'b1;
        load_value = 16'h0099;
        tick();
        load_valid = 1'b0;
        check("rst pending before", 32'(load_ready), 32'h0);
        rst_n = 1'b0;
        tick();
        check_pins("rst mid", 4'hF, 7'h7F);
        check("rst mid hex_digit", 32'(hex_digit), 32'h0);
        check("rst mid load_ready", 32'(load_ready), 32'h1);
        rst_n = 1'b1;
        advance(2);
        check_pins("rst after d0", 4'hE, 7'h40);
        for (int d = 1; d < 4; d++) begin
            advance(6);
            check_pins($sformatf("rst after d%0d", d), 4'hF, 7'h7F);
        end
        advance(6);
        check_pins("rst next frame d0", 4'hE, 7'h40);
        advance(6);
        check_pins("rst next frame d1", 4'hF, 7'h7F);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
